// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_TX serializer between N_REQ byte requesters.
// One requester is accepted per frame; its byte and the parity configuration
// are latched, Data_Valid is pulsed for one cycle, and the arbiter then
// follows the serializer's busy flag until the frame has been shifted out.
//
// Timeout: after the Data_Valid cycle the arbiter samples busy for BUSY_TO
// cycles. If busy never rises, err_timeout pulses in the following cycle
// (the first IDLE cycle) and the byte is dropped.
//
// frame_done and err_timeout are registered: they are high during the first
// IDLE cycle after a frame ends, and a new byte may be accepted in that cycle.
//
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins). The round-robin pointer then stays at its reset value, which
// makes the rotating search start at index 0 every time. Without the macro,
// arbitration is round-robin (the default).

module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int BUSY_TO = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       cfg_par_en,
  input  logic                       cfg_par_typ,
  output logic [DATA_W-1:0]          P_DATA,
  output logic                       Data_Valid,
  output logic                       PAR_EN,
  output logic                       PAR_TYP,
  input  logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       frame_done,
  output logic                       err_timeout
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t               state_reg;
  state_t               state_next;

  logic [ID_W-1:0]      ptr_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [DATA_W-1:0]    p_data_reg;
  logic                 par_en_reg;
  logic                 par_typ_reg;
  logic [ID_W-1:0]      grant_id_reg;
  logic                 frame_done_reg;
  logic                 err_timeout_reg;

  logic [DATA_W-1:0]    req_byte [N_REQ];
  logic [ID_W:0]        scan_idx;
  logic [ID_W-1:0]      win_idx;
  logic                 any_valid;
  logic                 accept;
  logic                 timeout_hit;
  logic                 done_hit;
  logic                 issue_pulse;
  logic                 grant_en;

  // Slice the flat request bus into one byte per requester.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Rotating search: scan from the farthest offset down to ptr+1 so the
  // last hit (the nearest valid index after the pointer) wins.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      scan_idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(N_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(N_REQ);
      end
      if (req_valid[scan_idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        win_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // Handshake and frame-end conditions shared by the FSM and datapath.
  always_comb begin
    accept      = (state_reg == S_IDLE) && RST && !busy && any_valid;
    timeout_hit = (state_reg == S_WAIT_BUSY) && !busy &&
                  (cnt_reg == CNT_W'(BUSY_TO - 1));
    done_hit    = (state_reg == S_WAIT_DONE) && !busy;
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          state_next = S_WAIT_DONE;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (done_hit) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM outputs: Data_Valid only in ISSUE, ready only on an IDLE accept.
  always_comb begin
    issue_pulse = (state_reg == S_ISSUE);
    grant_en    = accept;
  end

  // One-hot ready toward the winning requester.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_en && (win_idx == ID_W'(gi));
    end
  endgenerate

  // Frame latch, pointer, timeout counter and end-of-frame pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr_reg         <= ID_W'(N_REQ - 1);
      cnt_reg         <= '0;
      p_data_reg      <= '0;
      par_en_reg      <= 1'b0;
      par_typ_reg     <= 1'b0;
      grant_id_reg    <= '0;
      frame_done_reg  <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      frame_done_reg  <= done_hit;
      err_timeout_reg <= timeout_hit;
      if (accept) begin
        p_data_reg   <= req_byte[win_idx];
        par_en_reg   <= cfg_par_en;
        par_typ_reg  <= cfg_par_typ;
        grant_id_reg <= win_idx;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
        ptr_reg      <= win_idx;
`endif
      end
      if (state_reg == S_ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == S_WAIT_BUSY) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign P_DATA      = p_data_reg;
  assign PAR_EN      = par_en_reg;
  assign PAR_TYP     = par_typ_reg;
  assign grant_id    = grant_id_reg;
  assign frame_done  = frame_done_reg;
  assign err_timeout = err_timeout_reg;
  assign Data_Valid  = issue_pulse;

endmodule
